// File: rtl/alu_multicycle_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states, NZCV bit positions.
package alu_multicycle_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_ADC = 4'h1,
        OP_SUB = 4'h2,
        OP_SBC = 4'h3,
        OP_AND = 4'h4,
        OP_OR  = 4'h5,
        OP_XOR = 4'h6,
        OP_NOT = 4'h7,
        OP_MOV = 4'h8,
        OP_CMP = 4'h9,
        OP_LSL = 4'hA,
        OP_LSR = 4'hB,
        OP_ASR = 4'hC,
        OP_ROR = 4'hD,
        OP_MUL = 4'hE,
        OP_NOP = 4'hF
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

    // Bit positions inside the packed {N,Z,C,V} flag register
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic is_shift_op(input op_e op);
        return op inside {OP_LSL, OP_LSR, OP_ASR, OP_ROR};
    endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Issue/result bundle between the control unit (master) and the ALU (slave).
interface alu_multicycle_if
    import alu_multicycle_pkg::*;
#(
    parameter int WIDTH = 16
);
    logic             start;
    op_e              op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             result_we;
    logic             n;
    logic             z;
    logic             c;
    logic             v;

    modport master (
        output start, op, in1, in2,
        input  busy, done, result, result_we, n, z, c, v
    );

    modport slave (
        input  start, op, in1, in2,
        output busy, done, result, result_we, n, z, c, v
    );

endinterface

// File: rtl/alu_comb_core.sv
// Combinational add/sub/logic core with NZCV generation; also serves as the MUL accumulator.
module alu_comb_core
    import alu_multicycle_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  op_e              op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    input  logic             v_i,
    output logic [WIDTH-1:0] res_o,
    output logic             n_o,
    output logic             z_o,
    output logic             c_o,
    output logic             v_o
);
    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic [WIDTH:0]   sum;

    // Subtraction is A + ~B + carry; logic ops pass C and V through untouched
    always_comb begin
        b_eff = b_i;
        cin   = 1'b0;
        case (op_i)
            OP_ADC:         cin = c_i;
            OP_SUB, OP_CMP: begin b_eff = ~b_i; cin = 1'b1; end
            OP_SBC:         begin b_eff = ~b_i; cin = c_i;  end
            default:        ;
        endcase
        sum   = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        res_o = a_i;
        c_o   = c_i;
        v_o   = v_i;
        case (op_i)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP: begin
                res_o = sum[WIDTH-1:0];
                c_o   = sum[WIDTH];
                v_o   = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND:  res_o = a_i & b_i;
            OP_OR:   res_o = a_i | b_i;
            OP_XOR:  res_o = a_i ^ b_i;
            OP_NOT:  res_o = ~a_i;
            OP_MOV:  res_o = b_i;
            default: ;
        endcase
        n_o = res_o[WIDTH-1];
        z_o = (res_o == '0);
    end

endmodule

// File: rtl/alu_multicycle.sv
// Registered multi-cycle ALU: FSM, operand/shift/count registers and the NZCV flag register.
module alu_multicycle
    import alu_multicycle_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    alu_multicycle_if.slave bus
);
    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = SH_W + 1;

    state_e           state_q;
    op_e              op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] hi_q;
    logic [CNT_W-1:0] rem_q;
    logic             busy_q;
    logic             done_q;
    logic             we_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       nzcv_q;

    op_e              op_s;
    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic [WIDTH-1:0] hi_s;
    logic [CNT_W-1:0] rem_s;
    logic             is_mul;
    logic             is_sh;
    logic             last;
    logic [WIDTH-1:0] sh_val_d;
    logic             sh_out;
    op_e              core_op;
    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_b;
    logic [WIDTH-1:0] core_res;
    logic             core_n;
    logic             core_z;
    logic             core_c;
    logic             core_v;
    logic [WIDTH-1:0] mul_hi_d;
    logic [WIDTH-1:0] mul_lo_d;
    logic [WIDTH-1:0] result_d;
    logic [3:0]       nzcv_d;
    logic             we_d;

    // The first step runs on the issue edge straight from the bus, so an
    // N-step op raises done N-1 edges after issue; later steps use the registers.
    always_comb begin
        if (state_q == ST_IDLE) begin
            op_s = bus.op;
            a_s  = bus.in1;
            b_s  = bus.in2;
            hi_s = '0;
            if (bus.op == OP_MUL)          rem_s = CNT_W'(WIDTH);
            else if (is_shift_op(bus.op))  rem_s = {1'b0, bus.in2[SH_W-1:0]};
            else                           rem_s = '0;
        end else begin
            op_s  = op_q;
            a_s   = a_q;
            b_s   = b_q;
            hi_s  = hi_q;
            rem_s = rem_q;
        end
        is_mul = (op_s == OP_MUL);
        is_sh  = is_shift_op(op_s);
        last   = (rem_s <= CNT_W'(1));
    end

    // One-bit shift/rotate step; sh_out is the bit leaving the word
    always_comb begin
        sh_val_d = a_s;
        sh_out   = a_s[0];
        case (op_s)
            OP_LSL: begin sh_val_d = {a_s[WIDTH-2:0], 1'b0}; sh_out = a_s[WIDTH-1]; end
            OP_LSR: sh_val_d = {1'b0, a_s[WIDTH-1:1]};
            OP_ASR: sh_val_d = {a_s[WIDTH-1], a_s[WIDTH-1:1]};
            OP_ROR: sh_val_d = {a_s[0], a_s[WIDTH-1:1]};
            default: ;
        endcase
    end

    // MUL reuses the core as the accumulator: hi += lo[0] ? A : 0, then {c,hi,lo} >>= 1
    always_comb begin
        core_op  = is_mul ? OP_ADD : op_s;
        core_a   = is_mul ? hi_s : a_s;
        core_b   = is_mul ? (b_s[0] ? a_s : '0) : b_s;
        mul_hi_d = {core_c, core_res[WIDTH-1:1]};
        mul_lo_d = {core_res[0], b_s[WIDTH-1:1]};
    end

    alu_comb_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op_i  (core_op),
        .a_i   (core_a),
        .b_i   (core_b),
        .c_i   (nzcv_q[FLAG_C]),
        .v_i   (nzcv_q[FLAG_V]),
        .res_o (core_res),
        .n_o   (core_n),
        .z_o   (core_z),
        .c_o   (core_c),
        .v_o   (core_v)
    );

    // Result, flags and write-enable that get committed on the final step
    always_comb begin
        result_d = a_s;
        nzcv_d   = nzcv_q;
        we_d     = 1'b1;
        if (is_mul) begin
            result_d       = mul_lo_d;
            nzcv_d[FLAG_N] = mul_lo_d[WIDTH-1];
            nzcv_d[FLAG_Z] = (mul_lo_d == '0);
            nzcv_d[FLAG_C] = |mul_hi_d;
            nzcv_d[FLAG_V] = 1'b0;
        end else if (is_sh) begin
            if (rem_s != '0) begin
                result_d       = sh_val_d;
                nzcv_d[FLAG_C] = sh_out;
            end
            nzcv_d[FLAG_N] = result_d[WIDTH-1];
            nzcv_d[FLAG_Z] = (result_d == '0);
        end else if (op_s == OP_NOP) begin
            we_d = 1'b0;
        end else begin
            result_d = core_res;
            nzcv_d   = {core_n, core_z, core_c, core_v};
            we_d     = (op_s != OP_CMP);
        end
    end

    // FSM plus all datapath/flag state; done and result_we are one-cycle pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_NOP;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            rem_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
            result_q <= '0;
            nzcv_q   <= '0;
        end else begin
            done_q <= 1'b0;
            we_q   <= 1'b0;
            if (state_q == ST_EXEC && done_q) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else if (state_q == ST_EXEC || bus.start) begin
                state_q <= ST_EXEC;
                busy_q  <= 1'b1;
                op_q    <= op_s;
                a_q     <= is_mul ? a_s : sh_val_d;
                b_q     <= mul_lo_d;
                hi_q    <= mul_hi_d;
                rem_q   <= rem_s - CNT_W'(1);
                if (last) begin
                    done_q   <= 1'b1;
                    we_q     <= we_d;
                    result_q <= result_d;
                    nzcv_q   <= nzcv_d;
                end
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.result_we = we_q;
    assign bus.n         = nzcv_q[FLAG_N];
    assign bus.z         = nzcv_q[FLAG_Z];
    assign bus.c         = nzcv_q[FLAG_C];
    assign bus.v         = nzcv_q[FLAG_V];

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=16): arithmetic reference model + per-cycle compare.
module tb_alu_multicycle;
    import alu_multicycle_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_multicycle_if #(.WIDTH(16)) bus ();

    alu_multicycle #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state: what the outputs must look like right now
    logic        m_active = 1'b0;
    int          m_t = 0;
    int          m_end = 0;
    logic [15:0] m_res = '0;
    logic [3:0]  m_nzcv = '0;
    logic [15:0] x_res = '0;
    logic [3:0]  x_nzcv = '0;
    logic        x_we = 1'b0;
    bit          chk_en = 1'b0;
    int          done_cyc = -1;
    int          n_done = 0;
    logic        done_we = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic lit(input string name, input logic [15:0] r, input logic [3:0] f);
        chk({name, "_res"}, 32'(bus.result), 32'(r));
        chk({name, "_nzcv"}, 32'({bus.n, bus.z, bus.c, bus.v}), 32'(f));
    endtask

    // Architectural rules written as plain integer arithmetic
    function automatic void model(input op_e op, input logic [15:0] a, input logic [15:0] b,
                                  input logic [3:0] f, output logic [15:0] r,
                                  output logic [3:0] nf, output logic we, output int lat);
        int ua, ub, sa, sb, s, k, cin, brw, sv;
        logic [31:0] p;
        logic c, v;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        cin = int'(f[1]); c = f[1]; v = f[0];
        we = 1'b1; lat = 1; r = a; k = ub % 16;
        case (op)
            OP_ADD, OP_ADC: begin
                s  = ua + ub + ((op == OP_ADC) ? cin : 0);
                sv = sa + sb + ((op == OP_ADC) ? cin : 0);
                r = s[15:0]; c = (s > 65535); v = (sv > 32767) || (sv < -32768);
            end
            OP_SUB, OP_SBC, OP_CMP: begin
                brw = (op == OP_SBC) ? (1 - cin) : 0;
                s  = ua - ub - brw;
                sv = sa - sb - brw;
                r = s[15:0]; c = (s >= 0); v = (sv > 32767) || (sv < -32768);
                we = (op != OP_CMP);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOT: r = ~a;
            OP_MOV: r = b;
            OP_LSL: if (k != 0) begin r = 16'(ua << k); c = ((ua >> (16 - k)) & 1) != 0; end
            OP_LSR: if (k != 0) begin r = 16'(ua >> k); c = ((ua >> (k - 1)) & 1) != 0; end
            OP_ASR: if (k != 0) begin r = 16'(sa >>> k); c = ((ua >> (k - 1)) & 1) != 0; end
            OP_ROR: if (k != 0) begin r = 16'((ua >> k) | (ua << (16 - k))); c = r[15]; end
            OP_MUL: begin
                p = {16'd0, a} * {16'd0, b};
                r = p[15:0]; c = (p[31:16] != 0); v = 1'b0; lat = 16;
            end
            default: we = 1'b0;
        endcase
        if (op inside {OP_LSL, OP_LSR, OP_ASR, OP_ROR}) lat = (k == 0) ? 1 : k;
        nf = (op == OP_NOP) ? f : {r[15], (r == 16'd0), c, v};
    endfunction

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            logic eb, ed;
            eb = m_active && (cyc >= m_t) && (cyc <= m_end);
            ed = m_active && (cyc == m_end);
            if (ed) begin
                m_res  = x_res;
                m_nzcv = x_nzcv;
            end
            chk("busy", 32'(bus.busy), 32'(eb));
            chk("done", 32'(bus.done), 32'(ed));
            chk("result_we", 32'(bus.result_we), 32'(ed && x_we));
            chk("result", 32'(bus.result), 32'(m_res));
            chk("nzcv", 32'({bus.n, bus.z, bus.c, bus.v}), 32'(m_nzcv));
            if (bus.done) begin
                done_cyc = cyc;
                done_we  = bus.result_we;
                n_done++;
            end
        end
    end

    // Drive start for one edge; the model decides whether the edge accepts it
    task automatic issue(input op_e op, input logic [15:0] a, input logic [15:0] b, output int e);
        logic [15:0] r;
        logic [3:0]  nf;
        logic        we;
        int          lat;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.in1 = a; bus.in2 = b;
        @(posedge clk); #1;
        e = cyc;
        bus.start = 1'b0;
        if (!(m_active && (e <= m_end + 1))) begin
            model(op, a, b, m_nzcv, r, nf, we, lat);
            m_active = 1'b1; m_t = e; m_end = e + lat - 1;
            x_res = r; x_nzcv = nf; x_we = we;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_active && (cyc <= m_end) && (n < 64)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) chk("wait_idle_timeout", 32'(n), 32'(0));
        @(negedge clk);
    endtask

    task automatic run(input op_e op, input logic [15:0] a, input logic [15:0] b, output int e);
        issue(op, a, b, e);
        wait_idle();
    endtask

    typedef struct packed {
        op_e         op;
        logic [15:0] a;
        logic [15:0] b;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl [NV] = '{
        '{OP_ADD, 16'hFFFF, 16'hFFFF}, '{OP_ADC, 16'h0001, 16'h0001},
        '{OP_SUB, 16'h0000, 16'h0001}, '{OP_SBC, 16'h000A, 16'h0003},
        '{OP_SUB, 16'h0005, 16'h0005}, '{OP_SBC, 16'h0008, 16'h0008},
        '{OP_AND, 16'hF0F0, 16'h3C3C}, '{OP_OR,  16'h0F00, 16'h00F0},
        '{OP_NOT, 16'h00FF, 16'h1234}, '{OP_MOV, 16'h1111, 16'h8001},
        '{OP_ROR, 16'h0001, 16'h0001}, '{OP_LSL, 16'h0003, 16'h000F},
        '{OP_ASR, 16'h4000, 16'h0003}, '{OP_LSR, 16'h8000, 16'h000F},
        '{OP_ROR, 16'h12F4, 16'h0008}, '{OP_MUL, 16'hFFFF, 16'hFFFF}
    };

    initial begin
        int t, t2, t3, nd;
        rst = 1'b1;
        bus.start = 1'b0; bus.op = OP_NOP; bus.in1 = '0; bus.in2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", 32'({bus.busy, bus.done, bus.result_we}), 32'(0));
        lit("reset", 16'h0000, 4'b0000);
        rst = 1'b0;
        chk_en = 1'b1;

        run(OP_ADD, 16'h7FFF, 16'h0001, t);
        lit("add_ovf", 16'h8000, 4'b1001);
        chk("add_lat", 32'(done_cyc - t + 1), 32'(1));
        run(OP_SUB, 16'h0004, 16'h0002, t);  lit("sub_pos", 16'h0002, 4'b0010);
        run(OP_SUB, 16'h0002, 16'h0004, t);  lit("sub_neg", 16'hFFFE, 4'b1000);
        run(OP_CMP, 16'h8000, 16'h4000, t);  lit("cmp", 16'h4000, 4'b0011);
        chk("cmp_we", 32'(done_we), 32'(0));
        run(OP_ADD, 16'hFFFF, 16'h0001, t);  lit("add_wrap", 16'h0000, 4'b0110);
        run(OP_ADC, 16'h0000, 16'h0000, t);  lit("adc", 16'h0001, 4'b0000);
        run(OP_SBC, 16'h0005, 16'h0003, t);  lit("sbc_c0", 16'h0001, 4'b0010);

        nd = n_done;
        issue(OP_ASR, 16'h8000, 16'h0004, t);
        @(negedge clk);
        issue(OP_ADD, 16'h0001, 16'h0001, t2);
        wait_idle();
        lit("asr4", 16'hF800, 4'b1000);
        chk("asr_lat", 32'(done_cyc - t + 1), 32'(4));
        chk("asr_one_done", 32'(n_done - nd), 32'(1));
        run(OP_LSR, 16'h0003, 16'h0001, t);  lit("lsr1", 16'h0001, 4'b0010);
        run(OP_LSL, 16'h1234, 16'h0000, t);  lit("lsl0", 16'h1234, 4'b0010);
        chk("lsl0_lat", 32'(done_cyc - t + 1), 32'(1));

        run(OP_MUL, 16'h0100, 16'h0100, t);  lit("mul_hi", 16'h0000, 4'b0110);
        chk("mul_lat", 32'(done_cyc - t + 1), 32'(16));
        run(OP_MUL, 16'h00FF, 16'h0003, t);  lit("mul_lo", 16'h02FD, 4'b0000);

        nd = n_done;
        issue(OP_MUL, 16'h1234, 16'h5678, t);
        do @(negedge clk); while (cyc < t + 4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_active = 1'b0; m_res = '0; m_nzcv = '0;
        @(negedge clk);
        lit("rst_mid", 16'h0000, 4'b0000);
        chk("rst_mid_busy", 32'(bus.busy), 32'(0));
        chk("rst_mid_nodone", 32'(n_done - nd), 32'(0));
        run(OP_ADD, 16'h0002, 16'h0002, t);  lit("add_after_rst", 16'h0004, 4'b0000);

        issue(OP_ADD, 16'h0001, 16'h0001, t);
        issue(OP_SUB, 16'h0009, 16'h0009, t2);
        issue(OP_XOR, 16'hF0F0, 16'h0FF0, t3);
        wait_idle();
        lit("restart_xor", 16'hFF00, 4'b1000);
        chk("restart_edge", 32'(done_cyc - t), 32'(2));

        run(OP_NOP, 16'hABCD, 16'h0000, t);  lit("nop", 16'hABCD, 4'b1000);
        chk("nop_we", 32'(done_we), 32'(0));

        for (int unsigned i = 0; i < NV; i++) run(tbl[i].op, tbl[i].a, tbl[i].b, t);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
